// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the round-robin FIFO drain arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_BURST
    } arb_state_e;

    // Ceiling log2 for elaboration-time width calculation.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        longint unsigned x;
        r = 0;
        x = 1;
        while (x < longint'(v)) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Channel index width, never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning ptr, ptr+1, ... mod NUM_CH.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    localparam int unsigned CH_W = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              any
);

    int unsigned idx;

    // Walk the channels starting at ptr and latch the first requester.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = (32'(ptr) + i) % NUM_CH;
            if (!any && req[idx[CH_W-1:0]]) begin
                any     = 1'b1;
                gnt_idx = idx[CH_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_rr_drain_arb.sv
// Round-robin burst arbiter draining NUM_CH first-word-fall-through FIFOs into one
// registered valid/ready stream. Optional per-channel pop counters are enabled by
// defining FIFO_ARB_STATS_EN.
module fifo_rr_drain_arb
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 16,
    localparam int unsigned CH_W  = ch_width(NUM_CH),
    localparam int unsigned CNT_W = clog2(BURST_LEN) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]            ch_read,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         busy
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                         stats_clr,
    output logic [NUM_CH*32-1:0]         ch_words
`endif
);

    arb_state_e             state_q, state_d;
    logic [CH_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]        grant_q, grant_d;
    logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic                   out_valid_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic [CH_W-1:0]        out_ch_q;

    logic                   load;
    logic                   head_empty;
    logic [DATA_WIDTH-1:0]  head_data;
    logic [CH_W-1:0]        rr_next;
    logic [CH_W-1:0]        pick_idx;
    logic                   pick_any;

    fifo_rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .req     (~ch_empty),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Select the granted channel's head word and empty flag.
    always_comb begin
        head_empty = 1'b1;
        head_data  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant_q == CH_W'(i)) begin
                head_empty = ch_empty[i];
                head_data  = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rr_next = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);

    // Next-state logic: pick a channel in IDLE, pop up to BURST_LEN words in BURST.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        load        = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d     = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = ARB_BURST;
                end
            end
            ARB_BURST: begin
                load = (!out_valid_q || out_ready) && !head_empty;
                if (load) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
                // Empty check uses the live flag; a stale flag after the last pop just
                // costs one extra cycle here, never an underflow.
                if ((load && burst_cnt_q == CNT_W'(BURST_LEN - 1)) || head_empty) begin
                    state_d     = ARB_IDLE;
                    rr_ptr_d    = rr_next;
                    burst_cnt_d = '0;
                end
            end
        endcase
    end

    // FSM, grant, pointer and burst counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Output register; accept and load in the same cycle keeps the stream bubble-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= head_data;
            out_ch_q    <= grant_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // One-hot pop strobe, suppressed while reset is asserted.
    always_comb begin
        ch_read = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_read[i] = load && !rst && (grant_q == CH_W'(i));
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign busy      = (state_q == ARB_BURST) || out_valid_q;

`ifdef FIFO_ARB_STATS_EN
    logic [31:0] words_q [NUM_CH];

    // Saturating per-channel pop counters; clear wins over a same-cycle pop.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rst || stats_clr) begin
                words_q[i] <= '0;
            end else if (ch_read[i] && (words_q[i] != 32'hFFFF_FFFF)) begin
                words_q[i] <= words_q[i] + 32'd1;
            end
        end
    end

    // Flatten the counter array onto the output bus.
    always_comb begin
        ch_words = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_words[i*32 +: 32] = words_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rr_drain_arb.sv
// Scoreboard bench for fifo_rr_drain_arb: FIFOs are modelled as queues, the expected
// output order is derived from round-robin burst rules, and a monitor checks each
// accepted word. Define FIFO_ARB_STATS_EN to exercise the pop counters.
module tb_fifo_rr_drain_arb;

    localparam int NUM_CH = 4;
    localparam int DW     = 8;
    localparam int BL     = 16;
    localparam int CH_W   = 2;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [DW-1:0]   data;
    } exp_t;

    logic                   clk;
    logic                   rst;
    logic [NUM_CH-1:0]      ch_empty;
    logic [NUM_CH*DW-1:0]   ch_data;
    logic [NUM_CH-1:0]      ch_read;
    logic                   out_valid;
    logic                   out_ready;
    logic [DW-1:0]          out_data;
    logic [CH_W-1:0]        out_ch;
    logic                   busy;
`ifdef FIFO_ARB_STATS_EN
    logic                   stats_clr;
    logic [NUM_CH*32-1:0]   ch_words;
`endif

    fifo_rr_drain_arb #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_empty  (ch_empty),
        .ch_data   (ch_data),
        .ch_read   (ch_read),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .busy      (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .ch_words  (ch_words)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    int          n_acc = 0;
    int          cyc_cnt = 0;
    int          m_ptr = 0;
    int          rdy_mode = 0;  // 0 hold, 1 random, 2 toggle
    logic [DW-1:0] fq [NUM_CH][$];
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          pop_log[$];
    logic [NUM_CH-1:0] pend;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function automatic void refresh();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_empty[i] = (fq[i].size() == 0);
            ch_data[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    task automatic load(input int ch, input int n, input logic [DW-1:0] base, input bit rnd);
        for (int k = 0; k < n; k++) fq[ch].push_back(rnd ? DW'($urandom) : base + DW'(k));
        refresh();
    endtask

    // Expected output order: from the pointer, take the first non-empty channel,
    // emit up to BL of its words, move the pointer past it, repeat until all drained.
    task automatic predict();
        int pos[NUM_CH];
        int g;
        int n;
        bit found;
        for (int i = 0; i < NUM_CH; i++) pos[i] = 0;
        forever begin
            found = 0;
            g = 0;
            for (int k = 0; k < NUM_CH; k++) begin
                int c;
                c = (m_ptr + k) % NUM_CH;
                if (!found && fq[c].size() > pos[c]) begin
                    found = 1;
                    g = c;
                end
            end
            if (!found) break;
            n = fq[g].size() - pos[g];
            if (n > BL) n = BL;
            for (int j = 0; j < n; j++) exp_q.push_back('{ch: CH_W'(g), data: fq[g][pos[g]+j]});
            pos[g] += n;
            m_ptr = (g + 1) % NUM_CH;
        end
    endtask

    task automatic drain(input string nm);
        int t;
        int sz;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 3000) begin
            cyc();
            t++;
        end
        sz = exp_q.size();
        check(nm, 64'(sz) * 2 + 64'(busy), 0);
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        m_ptr = 0;
        exp_q.delete();
    endtask

    // FIFO model: sample pops at negedge, apply them just after the next posedge.
    always begin
        @(negedge clk);
        pend = ch_read;
        check("ch_read_rules",
              64'(((ch_read & (ch_read - NUM_CH'(1))) != 0) || ((ch_read & ch_empty) != 0) ||
                  (rst && ch_read != 0) || (ch_read != 0 && out_valid && !out_ready)), 0);
        @(posedge clk);
        #1;
        cyc_cnt++;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pend[i]) begin
                if (fq[i].size() > 0) void'(fq[i].pop_front());
                pop_log.push_back(cyc_cnt);
            end
        end
        #1;
        refresh();
    end

    // Consumer-side ready pattern.
    always begin
        @(posedge clk);
        #1;
        if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
        else if (rdy_mode == 2) out_ready = !out_ready;
    end

    // Scoreboard monitor: every accepted word must be the next expected one.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_word: got ch=%0d data=0x%0h, expected no word",
                         out_ch, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_word", 64'({out_ch, out_data}), 64'({mon_e.ch, mon_e.data}));
            end
            n_acc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        int d1, d2, d3, dx;
        rst = 1'b1;
        out_ready = 1'b1;
        ch_empty = '1;
        ch_data = '0;
`ifdef FIFO_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        cyc();

        // Reset held with every channel non-empty: no pops, no output.
        for (int i = 0; i < NUM_CH; i++) load(i, 1, DW'(8'h10 + i), 0);
        m_ptr = 0;
        predict();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_ch_read", 64'(ch_read), 0);
            check("rst_out_valid", 64'(out_valid), 0);
            check("rst_out_ch", 64'(out_ch), 0);
            cyc();
        end
        rst = 1'b0;
        drain("p1_drain");

        // Single channel, five words.
        load(2, 5, 8'hA0, 0);
        predict();
        drain("p2_drain");

        // All channels deep: 16-word bursts in rotation with one idle cycle between.
        do_reset();
        pop_log.delete();
        for (int i = 0; i < NUM_CH; i++) load(i, 40, DW'(i * 64), 0);
        predict();
        drain("p3_drain");
        d1 = 0; d2 = 0; d3 = 0; dx = 0;
        for (int k = 1; k < pop_log.size(); k++) begin
            int d;
            d = pop_log[k] - pop_log[k-1];
            if (d == 1) d1++;
            else if (d == 2) d2++;
            else if (d == 3) d3++;
            else dx++;
        end
        check("p3_pop_count", 64'(pop_log.size()), 160);
        check("p3_gap_in_burst", 64'(d1), 148);
        check("p3_gap_after_full_burst", 64'(d2), 8);
        check("p3_gap_after_short_burst", 64'(d3), 3);
        check("p3_gap_other", 64'(dx), 0);

        // Alternating backpressure.
        rdy_mode = 2;
        load(1, 8, 8'hB0, 0);
        predict();
        drain("p4_drain");
        rdy_mode = 0;
        out_ready = 1'b1;

        // Reset in the middle of a burst from ch3.
        n_acc = 0;
        load(3, 10, 8'hC0, 0);
        predict();
        t = 0;
        while (n_acc < 3 && t < 200) begin
            cyc();
            t++;
        end
        check("p5_three_accepted", 64'(n_acc >= 3), 1);
        rst = 1'b1;
        cyc();
        @(negedge clk);
        check("p5_out_valid_after_rst", 64'(out_valid), 0);
        cyc();
        exp_q.delete();
        m_ptr = 0;
        load(1, 2, 8'hD0, 0);
        check("p5_ch3_words_left", 64'(fq[3].size() > 0 && fq[3].size() <= 7), 1);
        predict();
        rst = 1'b0;
        drain("p5_drain");

        // Randomised contents and ready patterns.
        for (int r = 0; r < 8; r++) begin
            rdy_mode = (r % 3 == 2) ? 2 : 1;
            for (int i = 0; i < NUM_CH; i++) begin
                load(i, $urandom_range(0, 40), '0, 1);
            end
            predict();
            drain("rand_drain");
            rdy_mode = 0;
            out_ready = 1'b1;
        end

`ifdef FIFO_ARB_STATS_EN
        // Pop counters: clear, count, clear again.
        cyc();
        stats_clr = 1'b1;
        cyc();
        stats_clr = 1'b0;
        check("stats_cleared", 64'(ch_words != 0), 0);
        load(0, 20, 8'h20, 0);
        load(3, 7, 8'h70, 0);
        predict();
        drain("p6_drain");
        check("stats_ch0", 64'(ch_words[31:0]), 20);
        check("stats_ch1", 64'(ch_words[63:32]), 0);
        check("stats_ch3", 64'(ch_words[127:96]), 7);
        stats_clr = 1'b1;
        cyc();
        stats_clr = 1'b0;
        check("stats_clr_zero", 64'(ch_words != 0), 0);
`endif

        cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
